// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op code constants driven on the op bus by the E stage
//   - FSM state encoding
//   - is_long_op(): true for the ops that occupy the unit for a busy period
package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage <-> multiply/divide unit signal bundle.
//   start     launch op this cycle
//   op        operation code (mdu_pkg constants)
//   a, b      rs / rt operands
//   busy      long operation in flight
//   stall_req stall request to the D-stage hazard unit
//   hi, lo    architectural HI/LO registers
// master = pipeline side, slave = mdu.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall_req, hi, lo
    );

endinterface

// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO registers for the E stage.
// Ports:
//   clk    clock, all state on rising edge
//   reset  synchronous, active-high
//   bus    mdu_if.slave (start/op/a/b in; busy/stall_req/hi/lo out)
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
//
// state    | meaning
// ---------+------------------------------------------------------------
// MDU_IDLE | no long op in flight; accepts start, mthi/mtlo write HI/LO
// MDU_RUN  | result held in pending regs, counter runs down to commit
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(1);

    mdu_state_e    state, state_next;
    logic [CW-1:0] count, count_next;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   pending_hi, pending_lo;
    logic          pending_skip;

    logic          capture, commit, wr_hi, wr_lo;

    logic               signed_op, div_op, div_zero;
    logic signed [32:0] op_a, op_b, div_b;
    logic signed [63:0] product;
    logic [31:0]        res_hi, res_lo;

    // Operands are extended to 33 bits so one signed operator serves both
    // the signed and unsigned forms. A zero divisor is replaced by 1 only to
    // keep the divider output defined; that result is never committed.
    always_comb begin
        signed_op = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        div_op    = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
        div_zero  = (bus.b == 32'd0);
        op_a      = {signed_op & bus.a[31], bus.a};
        op_b      = {signed_op & bus.b[31], bus.b};
        div_b     = div_zero ? 33'sd1 : op_b;
        product   = op_a * op_b;
        if (div_op) begin
            res_hi = 32'(op_a % div_b);
            res_lo = 32'(op_a / div_b);
        end else begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        capture    = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (bus.start) begin
                    if (is_long_op(bus.op)) begin
                        state_next = MDU_RUN;
                        count_next = div_op ? DIV_LOAD : MULT_LOAD;
                        capture    = 1'b1;
                    end else begin
                        wr_hi = (bus.op == MDU_MTHI);
                        wr_lo = (bus.op == MDU_MTLO);
                    end
                end
            end
            MDU_RUN: begin
                count_next = count - 1'b1;
                if (count == CNT_LAST) begin
                    state_next = MDU_IDLE;
                    commit     = 1'b1;
                end
            end
            default: state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= MDU_IDLE;
            count        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            pending_hi   <= '0;
            pending_lo   <= '0;
            pending_skip <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (capture) begin
                pending_hi   <= res_hi;
                pending_lo   <= res_lo;
                pending_skip <= div_op & div_zero;
            end
            if (commit) begin
                if (!pending_skip) begin
                    hi_q <= pending_hi;
                    lo_q <= pending_lo;
                end
            end else begin
                if (wr_hi) hi_q <= bus.a;
                if (wr_lo) lo_q <= bus.a;
            end
        end
    end

    assign bus.busy      = (state == MDU_RUN);
    assign bus.stall_req = (state == MDU_RUN) | (bus.start & is_long_op(bus.op));
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. Directed scenarios followed by random
// operations, each compared against an arithmetic model of HI/LO.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;

    mdu_if bus();

    mdu #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one op on HI/LO, from the instruction rules.
    task automatic model_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, ma, mb, p, mq, mr, q, r;
        logic [63:0] up;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            MDU_MULT: begin
                p = sa * sb;
                {m_hi, m_lo} = p;
            end
            MDU_MULTU: begin
                up = {32'd0, av} * {32'd0, bv};
                {m_hi, m_lo} = up;
            end
            MDU_DIV: begin
                if (bv != 32'd0) begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    mq = ma / mb;
                    mr = ma % mb;
                    q  = ((sa < 0) != (sb < 0)) ? -mq : mq;
                    r  = (sa < 0) ? -mr : mr;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            MDU_DIVU: begin
                if (bv != 32'd0) begin
                    m_lo = av / bv;
                    m_hi = av % bv;
                end
            end
            MDU_MTHI: m_hi = av;
            MDU_MTLO: m_lo = av;
            default: ;
        endcase
    endtask

    // Called away from the clock edge; returns just after the cycle in which
    // the op's result became visible. With poke set, stray starts are thrown
    // at the unit while it is busy and must have no effect.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input bit poke, input string tag);
        int n;
        bit is_long;
        logic [31:0] old_hi, old_lo;
        is_long = (o == MDU_MULT) || (o == MDU_MULTU) || (o == MDU_DIV) || (o == MDU_DIVU);
        n       = ((o == MDU_DIV) || (o == MDU_DIVU)) ? DIV_N : MULT_N;
        old_hi  = m_hi;
        old_lo  = m_lo;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        #1;
        check({tag, " stall_req@start"}, 32'(bus.stall_req), 32'(is_long));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        model_op(o, av, bv);
        if (is_long) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s busy[%0d]", tag, i), 32'(bus.busy), 32'd1);
                check($sformatf("%s stall[%0d]", tag, i), 32'(bus.stall_req), 32'd1);
                check($sformatf("%s hi_hold[%0d]", tag, i), bus.hi, old_hi);
                check($sformatf("%s lo_hold[%0d]", tag, i), bus.lo, old_lo);
                if (poke && ($urandom_range(0, 2) == 0)) begin
                    bus.start = 1'b1;
                    bus.op    = 3'($urandom_range(1, 6));
                    bus.a     = $urandom;
                    bus.b     = $urandom;
                end
                @(posedge clk);
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        #1;
        check({tag, " busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, " stall_end"}, 32'(bus.stall_req), 32'd0);
        check({tag, " hi"}, bus.hi, m_hi);
        check({tag, " lo"}, bus.lo, m_lo);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        int          pick;

        bus.start = 1'b0;
        bus.op    = MDU_NONE;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset stall", 32'(bus.stall_req), 32'd0);
        reset = 1'b0;

        run_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu_max_x2");
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2");
        run_op(MDU_MTHI,  32'h11, 32'd0, 1'b0, "mthi_11");
        run_op(MDU_MTLO,  32'h22, 32'd0, 1'b0, "mtlo_22");
        run_op(MDU_DIVU,  32'd7, 32'd0, 1'b0, "divu_by0");
        run_op(MDU_DIV,   32'd9, 32'd0, 1'b1, "div_by0");
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(MDU_DIV,   32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_neg2");
        run_op(MDU_MTLO,  32'h5, 32'd0, 1'b0, "mtlo_5");
        run_op(MDU_MULT,  32'd4, 32'd4, 1'b0, "mult_4x4");
        run_op(MDU_NONE,  32'hAAAA, 32'h5555, 1'b0, "nop0");
        run_op(3'd7,      32'hAAAA, 32'h5555, 1'b0, "nop7");

        // Reset aborting a multiply, with a stray start while busy and a
        // start held alongside reset.
        run_op(MDU_MTHI, 32'h33, 32'd0, 1'b0, "mthi_33");
        bus.start = 1'b1;
        bus.op    = MDU_MULT;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        check("abort busy1", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("abort busy2", 32'(bus.busy), 32'd1);
        check("abort hi_hold", bus.hi, 32'h33);
        @(posedge clk);
        @(negedge clk);
        check("abort busy3", 32'(bus.busy), 32'd1);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = MDU_MTHI;
        bus.a     = 32'hDEAD;
        @(posedge clk);
        @(negedge clk);
        check("abort busy_after_reset", 32'(bus.busy), 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_prio hi", bus.hi, 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        #1;
        check("abort stall", 32'(bus.stall_req), 32'd0);
        run_op(MDU_MULTU, 32'd6, 32'd7, 1'b0, "post_reset_multu");

        for (int k = 0; k < 60; k++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            pick = $urandom_range(0, 7);
            if (pick == 0) r_b = 32'd0;
            else if (pick == 1) begin
                r_a = 32'h8000_0000;
                r_b = 32'hFFFF_FFFF;
            end else if (pick == 2) r_b = 32'($urandom_range(1, 9));
            run_op(r_op, r_a, r_b, 1'b1, $sformatf("rnd%0d_op%0d", k, r_op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
